// File: rtl/pc_unit_if.sv
// Control and data bundle between the decode/execute side and the PC stage.
interface pc_unit_if #(
   parameter int CNT_W = 32
);
   logic             stall;
   logic             branch_taken;
   logic             jump;
   logic             jump_reg;
   logic [31:0]      i_imm_ext;
   logic [25:0]      i_jtarget;
   logic [31:0]      i_rs_data;
   logic [31:0]      o_pc;
   logic [31:0]      o_pc_plus4;
   logic             o_redirect;
   logic             o_misalign;
   logic             o_halted;
   logic [CNT_W-1:0] o_retired;

   // Core side: drives the controls, consumes the PC.
   modport master (
      output stall, branch_taken, jump, jump_reg, i_imm_ext, i_jtarget, i_rs_data,
      input  o_pc, o_pc_plus4, o_redirect, o_misalign, o_halted, o_retired
   );

   // PC stage side.
   modport slave (
      input  stall, branch_taken, jump, jump_reg, i_imm_ext, i_jtarget, i_rs_data,
      output o_pc, o_pc_plus4, o_redirect, o_misalign, o_halted, o_retired
   );
endinterface

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, next-PC select, retired counter and
// misaligned jump-register trap.
//
//   state | meaning
//   RUN   | PC advances every unstalled cycle
//   HALT  | misaligned jr/jalr seen; all state frozen until reset
module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic     clk,
   input  logic     reset,
   pc_unit_if.slave bus
);

   typedef enum logic {RUN, HALT} state_t;

   state_t           state, state_next;
   logic [31:0]      pc, pc_next;
   logic [CNT_W-1:0] retired, retired_next;
   logic             redirect, redirect_next;

   logic [31:0] pc_plus4;
   logic [31:0] br_target;
   logic [31:0] jmp_target;

   assign pc_plus4   = pc + 32'd4;
   // Immediate is a word offset; the shift drops its top two bits.
   assign br_target  = pc_plus4 + (bus.i_imm_ext << 2);
   assign jmp_target = {pc_plus4[31:28], bus.i_jtarget, 2'b00};

   // State, PC, counter and redirect flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pc       <= RESET_PC;
         retired  <= '0;
         redirect <= 1'b0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         retired  <= retired_next;
         redirect <= redirect_next;
      end
   end

   // Next-state and next-PC selection; jr beats j beats branch beats sequential.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      retired_next  = retired;
      redirect_next = 1'b0;
      case (state)
         RUN: begin
            if (!bus.stall) begin
               if (bus.jump_reg && (bus.i_rs_data[1:0] != 2'b00)) begin
                  state_next = HALT;
               end else begin
                  retired_next = retired + 1'b1;
                  if (bus.jump_reg) begin
                     pc_next       = bus.i_rs_data;
                     redirect_next = 1'b1;
                  end else if (bus.jump) begin
                     pc_next       = jmp_target;
                     redirect_next = 1'b1;
                  end else if (bus.branch_taken) begin
                     pc_next       = br_target;
                     redirect_next = 1'b1;
                  end else begin
                     pc_next = pc_plus4;
                  end
               end
            end
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   // The misalign flag is the HALT state itself, so it is sticky until reset.
   assign bus.o_pc       = pc;
   assign bus.o_pc_plus4 = pc_plus4;
   assign bus.o_redirect = redirect;
   assign bus.o_misalign = (state == HALT);
   assign bus.o_halted   = (state == HALT);
   assign bus.o_retired  = retired;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a behavioural PC model.  A second
// instance with a 4-bit counter shares the stimulus to exercise counter wrap.
module tb_pc_unit;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic clk = 1'b0;
   logic reset;

   pc_unit_if #(.CNT_W(32)) bus_a ();
   pc_unit_if #(.CNT_W(4))  bus_b ();

   pc_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   pc_unit #(.RESET_PC(RST_PC), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   assign bus_b.stall        = bus_a.stall;
   assign bus_b.branch_taken = bus_a.branch_taken;
   assign bus_b.jump         = bus_a.jump;
   assign bus_b.jump_reg     = bus_a.jump_reg;
   assign bus_b.i_imm_ext    = bus_a.i_imm_ext;
   assign bus_b.i_jtarget    = bus_a.i_jtarget;
   assign bus_b.i_rs_data    = bus_a.i_rs_data;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [31:0] m_pc;
   logic [31:0] m_ret;
   logic        m_redirect;
   logic        m_halt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("pc",        bus_a.o_pc,       m_pc);
      check("pc_plus4",  bus_a.o_pc_plus4, m_pc + 32'd4);
      check("redirect",  {31'b0, bus_a.o_redirect}, {31'b0, m_redirect});
      check("misalign",  {31'b0, bus_a.o_misalign}, {31'b0, m_halt});
      check("halted",    {31'b0, bus_a.o_halted},   {31'b0, m_halt});
      check("retired",   bus_a.o_retired, m_ret);
      check("retired4",  {28'b0, bus_b.o_retired}, m_ret & 32'hF);
      check("b_pc",      bus_b.o_pc, m_pc);
   endtask

   // Apply one cycle of inputs, advance the model, clock, and compare.
   task automatic step(input logic rst, input logic st, input logic br, input logic j,
                       input logic jr, input logic [31:0] imm, input logic [25:0] jt,
                       input logic [31:0] rs);
      logic [31:0] nxt;
      reset              = rst;
      bus_a.stall        = st;
      bus_a.branch_taken = br;
      bus_a.jump         = j;
      bus_a.jump_reg     = jr;
      bus_a.i_imm_ext    = imm;
      bus_a.i_jtarget    = jt;
      bus_a.i_rs_data    = rs;
      if (rst) begin
         m_pc = RST_PC; m_ret = 0; m_redirect = 0; m_halt = 0;
      end else if (m_halt || st) begin
         m_redirect = 0;
      end else if (jr && (rs % 4 != 0)) begin
         m_halt = 1; m_redirect = 0;
      end else begin
         if (jr)      nxt = rs;
         else if (j)  nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, jt} * 32'd4);
         else if (br) nxt = m_pc + 32'd4 + imm * 32'd4;
         else         nxt = m_pc + 32'd4;
         m_pc       = nxt;
         m_ret      = m_ret + 1;
         m_redirect = jr | j | br;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
   endtask

   initial begin
      logic st, br, j, jr, rr;
      logic [31:0] rs;
      m_pc = 0; m_ret = 0; m_redirect = 0; m_halt = 0;
      reset = 1'b1;
      bus_a.stall = 0; bus_a.branch_taken = 0; bus_a.jump = 0; bus_a.jump_reg = 0;
      bus_a.i_imm_ext = 0; bus_a.i_jtarget = 0; bus_a.i_rs_data = 0;
      @(negedge clk);

      // Reset and three sequential advances.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(); idle(); idle();
      check("seq3_pc", bus_a.o_pc, 32'h0040_000C);
      check("seq3_ret", bus_a.o_retired, 32'd3);

      // Backward branch: 0040_0014 - 16.
      idle();
      step(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0);
      check("br_pc", bus_a.o_pc, 32'h0040_0004);
      idle();
      check("br_redir_once", {31'b0, bus_a.o_redirect}, 32'd0);

      // Jump outranks branch.
      step(0, 0, 0, 0, 1, 0, 0, 32'h3000_0000);
      step(0, 0, 1, 1, 0, 32'h0000_0100, 26'h000_0010, 0);
      check("jmp_pc", bus_a.o_pc, 32'h3000_0040);

      // Misaligned jr traps; later controls are dead until reset.
      step(0, 0, 0, 0, 1, 0, 0, 32'h0000_1002);
      check("trap_pc", bus_a.o_pc, 32'h3000_0040);
      step(0, 0, 0, 1, 0, 0, 26'h3FF_FFFF, 0);
      step(0, 0, 0, 0, 1, 0, 0, 32'h0000_2000);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      check("trap_reset_pc", bus_a.o_pc, RST_PC);

      // Stall swallows a jump.
      step(0, 1, 0, 1, 0, 0, 26'h123_4567, 0);
      step(0, 1, 0, 1, 0, 0, 26'h123_4567, 0);
      idle();
      check("stall_pc", bus_a.o_pc, RST_PC + 32'd4);

      // PC wraps at the top of the address space.
      step(0, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC);
      check("top_plus4", bus_a.o_pc_plus4, 32'h0);
      idle();
      check("wrap_pc", bus_a.o_pc, 32'h0);

      // 4-bit counter wraps after 16 advances.
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) idle();
      check("cnt4_wrap", {28'b0, bus_b.o_retired}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rr = m_halt ? ($urandom_range(7) == 0) : ($urandom_range(63) == 0);
         st = ($urandom_range(3) == 0);
         br = ($urandom_range(2) == 0);
         j  = ($urandom_range(3) == 0);
         jr = ($urandom_range(3) == 0);
         rs = $urandom;
         if ($urandom_range(15) != 0) rs[1:0] = 2'b00;
         step(rr, st, br, j, jr, $urandom, 26'($urandom), rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
